microcode_loader: RTL

//  Writer side of the micro_memory: receives a byte stream and writes 20-bit microinstructions

---
 rtl/cu_pkg.sv | 22 ++
 rtl/microcode_loader_assembler.sv | 26 ++
 rtl/microcode_loader.sv | 77 +++++++
 3 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: micro-field layout, loader state encoding and register control codes shared with control_unit
package cu_pkg;
    localparam int F1_W   = 3;
    localparam int F2_W   = 3;
    localparam int F3_W   = 3;
    localparam int CD_W   = 2;
    localparam int BR_W   = 2;
    localparam int ADDR_W = 7;
    localparam int WORD_W = F1_W + F2_W + F3_W + CD_W + BR_W + ADDR_W;
    localparam int ADDR_LSB = 0;
    localparam int BR_LSB   = ADDR_LSB + ADDR_W;
    localparam int CD_LSB   = BR_LSB + BR_W;
    localparam int F3_LSB   = CD_LSB + CD_W;
    localparam int F2_LSB   = F3_LSB + F3_W;
    localparam int F1_LSB   = F2_LSB + F2_W;
    localparam logic [2:0] LOAD = 3'b100;
    localparam logic [2:0] CLR  = 3'b010;
    localparam logic [2:0] INC  = 3'b001;
    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_B0, S_B1, S_B2, S_WR, S_CHK, S_DONE, S_ERR
    } ld_state_t;
endpackage

// File: rtl/microcode_loader_assembler.sv
// mc_word_assembler: shifts stream bytes into a microinstruction and keeps the running XOR checksum
module mc_word_assembler #(
    parameter int WORD_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              shift,
    input  logic              acc,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic [7:0]        csum
);
    logic [WORD_W-9:0] sr;
    // the third byte completes the word combinationally so the top can latch it on that transfer
    assign word = {sr, byte_in};
    always_ff @(posedge clk) begin
        if (reset) begin
            sr   <= '0;
            csum <= '0;
        end else begin
            if (shift) sr <= {sr[WORD_W-17:0], byte_in};
            csum <= clr ? 8'h00 : acc ? csum ^ byte_in : csum;
        end
    end
endmodule

// File: rtl/microcode_loader.sv
// microcode_loader: receives a framed byte stream, writes the control store and holds the sequencer until a verified load
module microcode_loader #(
    parameter int ADDR_W = cu_pkg::ADDR_W,
    parameter int WORD_W = cu_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_din,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);
    import cu_pkg::*;
    ld_state_t         state;
    logic [ADDR_W-1:0] last_idx;
    logic              xfer;
    logic              start_ok;
    logic [2:0]        addr_op;
    logic [WORD_W-1:0] word;
    logic [7:0]        csum;
    assign byte_ready = state inside {S_HDR, S_B0, S_B1, S_B2, S_CHK};
    assign busy       = state inside {S_HDR, S_B0, S_B1, S_B2, S_WR, S_CHK};
    assign done       = state == S_DONE;
    assign error      = state == S_ERR;
    assign cpu_hold   = state != S_DONE;
    assign mem_wen    = state == S_WR;
    assign xfer       = byte_valid & byte_ready;
    assign start_ok   = start & (state inside {S_IDLE, S_DONE, S_ERR});
    assign addr_op    = start_ok ? CLR : state == S_WR ? INC : 3'b000;
    mc_word_assembler #(.WORD_W(WORD_W)) u_asm (
        .clk     (clk),
        .reset   (reset),
        .clr     (start_ok),
        .shift   (xfer & (state inside {S_B0, S_B1})),
        .acc     (xfer & (state != S_CHK)),
        .byte_in (byte_in),
        .word    (word),
        .csum    (csum)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            mem_addr   <= '0;
            mem_din    <= '0;
            word_count <= '0;
            last_idx   <= '0;
        end else begin
            mem_addr   <= addr_op == CLR ? '0 : addr_op == INC ? mem_addr + 1'b1 : mem_addr;
            word_count <= start_ok ? '0 : state == S_WR ? word_count + 1'b1 : word_count;
            case (state)
                S_IDLE, S_DONE, S_ERR: if (start_ok) state <= S_HDR;
                S_HDR: if (xfer) begin
                    last_idx <= byte_in[ADDR_W-1:0];
                    state    <= S_B0;
                end
                S_B0:  if (xfer) state <= |byte_in[7:4] ? S_ERR : S_B1;
                S_B1:  if (xfer) state <= S_B2;
                S_B2:  if (xfer) begin
                    mem_din <= word;
                    state   <= S_WR;
                end
                // word_count is the pre-increment index of the word just written
                S_WR:  state <= word_count < {1'b0, last_idx} ? S_B0 : S_CHK;
                S_CHK: if (xfer) state <= byte_in == csum ? S_DONE : S_ERR;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
